// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and transmit-feeder state encodings.
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    FEED_IDLE      = 2'd0,
    FEED_WAIT_BUSY = 2'd1,
    FEED_WAIT_DONE = 2'd2
  } feed_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with registered occupancy flags, overflow pulse
// and a synchronous flush that discards all stored entries.
module sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              flush,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              ovf_q, ovf_d;
  logic              wr_acc, rd_acc;

  // Accept/pop decisions, pointer and occupancy next state; flush wins.
  always_comb begin
    wr_acc  = wr_en && !full_q && !flush;
    rd_acc  = rd_en && !empty_q && !flush;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = wr_en && full_q;
    if (flush) begin
      rptr_d  = wptr_q;
      count_d = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + ADDR_W'(1);
      if (rd_acc) rptr_d = rptr_q + ADDR_W'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + (ADDR_W+1)'(1);
        2'b01:   count_d = count_q - (ADDR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
    full_d  = (count_d == {1'b1, {ADDR_W{1'b0}}});
    empty_d = (count_d == '0);
  end

  // Pointer, occupancy and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage array write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q] <= wr_data;
  end

  assign rd_data  = mem_q[rptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer: queues bytes and feeds them one at a time to the UART
// transmitter through the tx_start / tx_done handshake.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = uart_pkg::DATA_W,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              tx_done,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data
);

  feed_state_e       state_q, state_d;
  logic              tx_start_q, tx_start_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              pop;
  logic [DATA_W-1:0] rd_data;

  sync_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .flush    (flush),
    .rd_data  (rd_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  // Feeder next-state: pop in idle, then wait for the transmitter to go busy
  // and come back idle before the next pop.
  always_comb begin
    state_d    = state_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
    case (state_q)
      FEED_IDLE: begin
        tx_start_d = 1'b0;
        if (!empty && tx_done && !flush) begin
          pop        = 1'b1;
          tx_data_d  = rd_data;
          tx_start_d = 1'b1;
          state_d    = FEED_WAIT_BUSY;
        end
      end
      FEED_WAIT_BUSY: begin
        tx_start_d = 1'b1;
        if (!tx_done) begin
          tx_start_d = 1'b0;
          state_d    = FEED_WAIT_DONE;
        end
      end
      FEED_WAIT_DONE: begin
        tx_start_d = 1'b0;
        if (tx_done) state_d = FEED_IDLE;
      end
      default: begin
        tx_start_d = 1'b0;
        state_d    = FEED_IDLE;
      end
    endcase
  end

  // Feeder state and registered transmitter outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FEED_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_uart_tx_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          flush;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          tx_done;
  logic          tx_start;
  logic [DW-1:0] tx_data;

  uart_tx_fifo #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_done  (tx_done),
    .tx_start (tx_start),
    .tx_data  (tx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: byte queue plus handshake phase
  // (0 ready to send, 1 waiting for transmitter busy, 2 waiting for idle).
  logic [7:0] m_q[$];
  int         m_phase;
  logic       m_start;
  logic [7:0] m_data;
  logic       m_ovf;

  // Transmitter model.
  bit xm_en, xm_rand;
  int xm_st, xm_cnt, xm_dly, xm_frame;

  logic [7:0] sent[$];
  logic       prev_start;

  task automatic model_reset();
    m_q.delete();
    m_phase    = 0;
    m_start    = 1'b0;
    m_data     = 8'h00;
    m_ovf      = 1'b0;
    prev_start = 1'b0;
    xm_st      = 0;
  endtask

  task automatic xmit_model();
    case (xm_st)
      0: if (tx_start) begin
        if (xm_rand) begin
          xm_dly   = $urandom_range(0, 4);
          xm_frame = $urandom_range(1, 10);
        end
        xm_cnt = xm_dly;
        if (xm_cnt == 0) begin
          tx_done = 1'b0; xm_cnt = xm_frame; xm_st = 2;
        end else xm_st = 1;
      end
      1: begin
        xm_cnt--;
        if (xm_cnt == 0) begin tx_done = 1'b0; xm_cnt = xm_frame; xm_st = 2; end
      end
      default: begin
        xm_cnt--;
        if (xm_cnt == 0) begin tx_done = 1'b1; xm_st = 0; end
      end
    endcase
  endtask

  // One clock: predict from current inputs, clock, compare all outputs.
  task automatic step();
    bit pop, acc;
    pop   = !flush && (m_phase == 0) && (m_q.size() != 0) && tx_done;
    acc   = wr_en && !flush && (m_q.size() < DEPTH);
    m_ovf = wr_en && (m_q.size() == DEPTH);
    if (flush) m_q.delete();
    else begin
      if (pop) m_data = m_q.pop_front();
      if (acc) m_q.push_back(wr_data);
    end
    case (m_phase)
      0: if (pop) begin m_phase = 1; m_start = 1'b1; end
      1: if (!tx_done) begin m_phase = 2; m_start = 1'b0; end
      default: if (tx_done) m_phase = 0;
    endcase
    @(posedge clk); #1;
    chk("count",    32'(count),    32'(m_q.size()));
    chk("empty",    32'(empty),    32'(m_q.size() == 0));
    chk("full",     32'(full),     32'(m_q.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("tx_start", 32'(tx_start), 32'(m_start));
    chk("tx_data",  32'(tx_data),  32'(m_data));
    if (tx_start && !prev_start) sent.push_back(tx_data);
    prev_start = tx_start;
    if (xm_en) xmit_model();
  endtask

  task automatic idle(input int n);
    wr_en = 1'b0; flush = 1'b0;
    repeat (n) step();
  endtask

  task automatic put(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d; flush = 1'b0;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_en = 1'b0; flush = 1'b0; wr_data = '0; tx_done = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    chk("rst_count", 32'(count),    32'd0);
    chk("rst_empty", 32'(empty),    32'd1);
    chk("rst_full",  32'(full),     32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    chk("rst_start", 32'(tx_start), 32'd0);
    chk("rst_data",  32'(tx_data),  32'h00);
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       fl;
    logic       td;
    logic [4:0] cnt;
    logic       emp;
    logic       st;
    logic [7:0] data;
  } vec_t;

  vec_t       vt[10];
  logic [7:0] exp_b[$];

  initial begin
    vt[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 8'h00};
    vt[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 8'hA5};
    vt[2] = '{1'b1, 8'h5A, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1, 8'hA5};
    vt[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'hA5};
    vt[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'hA5};
    vt[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 8'hA5};
    vt[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 8'h5A};
    vt[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 8'h5A};
    vt[8] = '{1'b1, 8'h77, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 8'h5A};
    vt[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 8'h5A};

    xm_en = 0; xm_rand = 0; xm_dly = 3; xm_frame = 40;
    do_reset();

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      wr_en = vt[i].wr; wr_data = vt[i].d; flush = vt[i].fl; tx_done = vt[i].td;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_count", i), 32'(count),    32'(vt[i].cnt));
      chk($sformatf("vec%0d_empty", i), 32'(empty),    32'(vt[i].emp));
      chk($sformatf("vec%0d_start", i), 32'(tx_start), 32'(vt[i].st));
      chk($sformatf("vec%0d_data", i),  32'(tx_data),  32'(vt[i].data));
      chk($sformatf("vec%0d_ovf", i),   32'(overflow), 32'd0);
    end

    // Asynchronous reset in the middle of WAIT_BUSY.
    wr_en = 1'b1; wr_data = 8'hC3; flush = 1'b0; tx_done = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(posedge clk); #1;
    chk("busy_start", 32'(tx_start), 32'd1);
    chk("busy_data",  32'(tx_data),  32'hC3);
    #3 rst_n = 1'b0;
    #1;
    chk("async_start", 32'(tx_start), 32'd0);
    chk("async_data",  32'(tx_data),  32'h00);
    chk("async_count", 32'(count),    32'd0);
    do_reset();

    // Single byte with a slow transmitter.
    xm_en = 1; xm_rand = 0; xm_dly = 3; xm_frame = 40; xm_st = 0; tx_done = 1'b1;
    sent.delete();
    put(8'hA5);
    idle(60);
    chk("single_n", 32'(sent.size()), 32'd1);
    if (sent.size() > 0) chk("single_b", 32'(sent[0]), 32'hA5);

    // Ordering across pointer wrap, paced to stay below full.
    xm_dly = 1; xm_frame = 4;
    sent.delete();
    for (int i = 0; i < 20; i++) begin
      put(8'(i));
      idle(3);
    end
    idle(200);
    chk("order_n", 32'(sent.size()), 32'd20);
    for (int i = 0; i < 20 && i < sent.size(); i++)
      chk($sformatf("order_b%0d", i), 32'(sent[i]), 32'(i));

    // Fill to full with the transmitter stalled, then overflow.
    xm_en = 0; tx_done = 1'b0;
    sent.delete(); exp_b.delete();
    for (int i = 0; i < 16; i++) begin
      exp_b.push_back(8'($urandom));
      put(exp_b[i]);
    end
    chk("full_flag",  32'(full),  32'd1);
    chk("full_count", 32'(count), 32'd16);
    put(8'hEE);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count),    32'd16);
    idle(1);
    chk("ovf_clear", 32'(overflow), 32'd0);
    xm_en = 1; xm_dly = 2; xm_frame = 3; xm_st = 0; tx_done = 1'b1;
    idle(220);
    chk("drain_n", 32'(sent.size()), 32'd16);
    for (int i = 0; i < 16 && i < sent.size(); i++)
      chk($sformatf("drain_b%0d", i), 32'(sent[i]), 32'(exp_b[i]));

    // Write on the same edge as a pop.
    xm_en = 0; tx_done = 1'b0;
    sent.delete(); exp_b.delete();
    for (int i = 0; i < 5; i++) begin
      exp_b.push_back(8'($urandom));
      put(exp_b[i]);
    end
    wr_en = 1'b1; wr_data = 8'h3C; tx_done = 1'b1;
    step();
    wr_en = 1'b0;
    chk("simul_count", 32'(count),    32'd5);
    chk("simul_start", 32'(tx_start), 32'd1);
    xm_en = 1; xm_st = 0;
    xmit_model();
    idle(150);
    chk("simul_n", 32'(sent.size()), 32'd6);
    if (sent.size() == 6) begin
      chk("simul_first", 32'(sent[0]), 32'(exp_b[0]));
      chk("simul_last",  32'(sent[5]), 32'h3C);
    end

    // Flush with a write while a byte is in flight.
    xm_en = 0; tx_done = 1'b0;
    sent.delete();
    put(8'h11);
    for (int i = 0; i < 6; i++) put(8'($urandom));
    tx_done = 1'b1;
    step();
    chk("pre_flush_count", 32'(count),   32'd6);
    chk("pre_flush_data",  32'(tx_data), 32'h11);
    xm_en = 1; xm_dly = 3; xm_frame = 10; xm_st = 0;
    xmit_model();
    wr_en = 1'b1; wr_data = 8'hEE; flush = 1'b1;
    step();
    wr_en = 1'b0; flush = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    idle(60);
    chk("flush_sent_n", 32'(sent.size()), 32'd1);
    if (sent.size() > 0) chk("flush_sent_b", 32'(sent[0]), 32'h11);

    // Randomized traffic against the model.
    xm_rand = 1;
    for (int i = 0; i < 1500; i++) begin
      wr_en   = ($urandom_range(0, 99) < 45);
      wr_data = 8'($urandom);
      flush   = ($urandom_range(0, 63) == 0);
      step();
    end
    idle(100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Transmit-side buffer that sits directly upstream of the UART transmitter. It accepts bytes from the system side into a circular FIFO. It pops one byte at a time and presents it on tx_data. It then runs the tx_start / tx_done handshake with the transmitter until that byte has been sent. The block and the transmitter share one clock; any baud-rate tick gating is inside the transmitter.

Parameters:
DATA_W, 8, width of each stored byte and of tx_data
ADDR_W, 4, log2 of FIFO depth (default depth is 16 entries)

Ports:
clk  input  1  system clock; all logic acts on the rising edge
rst_n  input  1  asynchronous, active-low reset
wr_en  input  1  write strobe; wr_data is captured on an edge where wr_en=1
wr_data  input  DATA_W  byte to enqueue
flush  input  1  synchronous clear of the stored entries; the in-flight byte is unaffected
full  output  1  FIFO holds 2^ADDR_W entries
empty  output  1  FIFO holds 0 entries
count  output  ADDR_W+1  current occupancy, range 0..2^ADDR_W
overflow  output  1  one-cycle pulse when a write is dropped
tx_done  input  1  from the transmitter; high while the transmitter is idle
tx_start  output  1  request to the transmitter to send tx_data
tx_data  output  DATA_W  byte being sent; stable from pop until the byte completes

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Read and write pointers = 0, count=0, empty=1, full=0, overflow=0.
  - tx_start=0, tx_data=0, feeder FSM = IDLE.
  - Reset takes effect mid-transfer; the partially sent byte is abandoned.
- Storage and status:
  - Storage is a 2^ADDR_W x DATA_W array. Pointers wrap modulo 2^ADDR_W.
  - count, full and empty are registered and are derived only from count.
- Write:
  - When wr_en=1 and full=0, the byte is stored at wptr, wptr is incremented, and count rises by one.
  - When wr_en=1 and full=1, the byte is dropped and overflow=1 for exactly that cycle. This holds even if a pop happens on the same edge; full is the registered value.
- Pop:
  - A pop occurs only in FSM IDLE. tx_data <= mem[rptr], then rptr is incremented and count falls by one.
  - Write and pop on the same edge: both take effect and count is unchanged.
  - There is no fall-through path. A byte written at edge E0 is popped at E1 at the earliest, so tx_start is high after E1.
- Flush:
  - rptr<=wptr, count<=0, empty<=1, full<=0.
  - Flush has priority over a write and over a pop on the same edge.
  - The FSM state, tx_start and tx_data are unaffected.
- Feeder FSM states:
  - IDLE:
    - if empty=0 and tx_done=1 (and flush=0): pop, set tx_start<=1, go to WAIT_BUSY
    - otherwise: stay in IDLE with tx_start=0
  - WAIT_BUSY:
    - hold tx_start=1 and hold tx_data
    - when tx_done=0 is sampled: tx_start<=0, go to WAIT_DONE
  - WAIT_DONE:
    - hold tx_data
    - when tx_done=1 is sampled: go to IDLE
    - a back-to-back pop is therefore possible one edge after returning to IDLE
- Any state code outside these three returns the FSM to IDLE with tx_start=0.
- tx_start and tx_data are registered outputs with no combinational path from the inputs.
- Throughput: at most one byte per transmitter frame plus 2 clk cycles of handshake overhead.

Decomposition:
- Package uart_pkg:
  - DATA_W default
  - feeder state encodings, 2 bits: IDLE=2'd0, WAIT_BUSY=2'd1, WAIT_DONE=2'd2
  - a shared DATA_W constant, also used by the transmitter and receiver
- Sub-module sync_fifo (parameters DATA_W, ADDR_W) holds the storage, pointers, count/full/empty, overflow and flush.
- uart_tx_fifo instantiates sync_fifo and contains the feeder FSM.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release. Expect empty=1, full=0, count=0, tx_start=0, tx_data=8'h00. Then assert rst_n=0 mid-WAIT_BUSY; expect tx_start=0 immediately, without waiting for a clock edge.
- Single byte: write 8'hA5 at edge E0 with a transmitter model that drops tx_done 3 cycles after tx_start and raises it 40 cycles later. Expect tx_start=1 after E1 with tx_data=8'hA5, count back to 0, and tx_start low one edge after tx_done=0. tx_data must stay 8'hA5 until tx_done returns high.
- Ordering/wrap: write 20 bytes 8'h00..8'h13 with the transmitter model enabled, pacing writes so that full never asserts. Expect tx_data to present 00..13 in order, covering pointer wrap at 16.
- Full/overflow: hold tx_done=0 and write 17 bytes. Expect full=1 and count=16 after the 16th write. The 17th write must pulse overflow for one cycle and leave count at 16; a later drain must yield only the first 16 bytes.
- Simultaneous write+pop: with count=5, FSM in IDLE and tx_done=1, write 8'h3C on the pop edge. Expect count to remain 5 and 8'h3C to be transmitted last.
- Flush: with 6 bytes queued and byte 8'h11 in flight, pulse flush together with wr_en. Expect count=0 and empty=1, the write discarded, and 8'h11 still completing. No further tx_start may assert.
